// File: rtl/simd_pe_pkg.sv
// Shared types and helpers for the SIMD multiply-accumulate processing element.
package simd_pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pe_state_t;

    // Parameter legality; the element needs at least two lanes and room for a full product.
    function automatic logic params_ok(input int n, input int dw, input int aw);
        return (n >= 2) && (aw >= 2 * dw);
    endfunction

    // Returns {overflow, clamp_to_max} from the top two bits of an AW+1 bit sum.
    // Unsigned sums only ever overflow upwards; signed ones clamp toward the true sign.
    function automatic logic [1:0] add_ovf(input logic is_signed, input logic sum_top,
                                           input logic sum_msb);
        logic [1:0] res;
        if (is_signed) begin
            res = {sum_top ^ sum_msb, ~sum_top};
        end else begin
            res = {sum_top, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Product register plus saturating/wrapping accumulator with sticky overflow.
module pe_mac_unit
    import simd_pe_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 64,
    parameter int SAT = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [DW-1:0] a_elem,
    input  logic [DW-1:0] b_elem,
    input  logic          is_signed,
    input  logic          issue,
    input  logic          clr,
    output logic [AW-1:0] acc,
    output logic          ovf
);

    logic [2*DW-1:0]    a_ext, b_ext, p_next, p_reg;
    logic               p_valid_reg;
    logic [AW+2*DW-1:0] p_wide;
    logic [AW-1:0]      p_ext, acc_reg, acc_next, sat_hi, sat_lo;
    logic [AW:0]        sum;
    logic [1:0]         ovf_info;
    logic               ovf_reg;

    // The low 2*DW bits of a product of sign-extended operands are the signed product.
    assign a_ext  = {{DW{is_signed & a_elem[DW-1]}}, a_elem};
    assign b_ext  = {{DW{is_signed & b_elem[DW-1]}}, b_elem};
    assign p_next = a_ext * b_ext;

    assign p_wide = {{AW{is_signed & p_reg[2*DW-1]}}, p_reg};
    assign p_ext  = p_wide[AW-1:0];

    assign sum      = {is_signed & acc_reg[AW-1], acc_reg} + {is_signed & p_ext[AW-1], p_ext};
    assign ovf_info = add_ovf(is_signed, sum[AW], sum[AW-1]);
    assign sat_hi   = {~is_signed, {(AW-1){1'b1}}};
    assign sat_lo   = {is_signed, {(AW-1){1'b0}}};

    always_comb begin
        acc_next = sum[AW-1:0];
        if (ovf_info[1] && (SAT != 0)) begin
            acc_next = ovf_info[0] ? sat_hi : sat_lo;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            p_reg       <= '0;
            p_valid_reg <= 1'b0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            p_valid_reg <= issue;
            if (issue) begin
                p_reg <= p_next;
            end
            if (clr) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (p_valid_reg) begin
                acc_reg <= acc_next;
                ovf_reg <= ovf_reg | ovf_info[1];
            end
        end
    end

    assign acc = acc_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/simd_mac_pe.sv
// SIMD lane dot-product engine: operand vector storage, command FSM and issue index.
module simd_mac_pe
    import simd_pe_pkg::*;
#(
    parameter int N   = 16,
    parameter int DW  = 32,
    parameter int AW  = 64,
    parameter int SAT = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic [N-1:0][DW-1:0]       VEC_IN,
    input  logic                       VEC_SEL,
    input  logic                       VEC_VALID,
    output logic                       VEC_READY,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [$clog2(N+1)-1:0]     CMD_LEN,
    input  logic                       CMD_SIGNED,
    input  logic                       CMD_CLR,
    output logic [AW-1:0]              RES_DATA,
    output logic                       RES_OVF,
    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic [$clog2(N)-1:0]       IDX,
    output logic                       BUSY
);

    localparam int LW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    generate
        if (!params_ok(N, DW, AW)) begin : g_bad_params
            $error("simd_mac_pe: requires N >= 2 and AW >= 2*DW");
        end
    endgenerate

    pe_state_t            state_reg, state_next;
    logic [N-1:0][DW-1:0] vec_a_reg, vec_b_reg;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [LW-1:0]        len_reg, len_eff;
    logic                 signed_reg;
    logic                 vec_fire, cmd_fire, issue, last_issue;

    assign len_eff    = (CMD_LEN > LW'(N)) ? LW'(N) : CMD_LEN;
    assign vec_fire   = VEC_VALID && (state_reg == IDLE);
    assign cmd_fire   = CMD_VALID && (state_reg == IDLE);
    assign issue      = (state_reg == RUN);
    assign last_issue = ((LW'(idx_reg) + LW'(1)) == len_reg);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    idx_next   = '0;
                    state_next = (len_eff != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    if (RES_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            len_reg    <= '0;
            signed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (cmd_fire) begin
                len_reg    <= len_eff;
                signed_reg <= CMD_SIGNED;
            end
        end
    end

    // Vector write lands on the same edge as a command, so that command sees the new data.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vec_a_reg <= '0;
            vec_b_reg <= '0;
        end else if (vec_fire) begin
            if (VEC_SEL) begin
                vec_b_reg <= VEC_IN;
            end else begin
                vec_a_reg <= VEC_IN;
            end
        end
    end

    pe_mac_unit #(
        .DW  (DW),
        .AW  (AW),
        .SAT (SAT)
    ) u_mac (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .a_elem    (vec_a_reg[idx_reg]),
        .b_elem    (vec_b_reg[idx_reg]),
        .is_signed (signed_reg),
        .issue     (issue),
        .clr       (cmd_fire && CMD_CLR),
        .acc       (RES_DATA),
        .ovf       (RES_OVF)
    );

    assign VEC_READY = (state_reg == IDLE);
    assign CMD_READY = (state_reg == IDLE);
    assign RES_VALID = (state_reg == DONE);
    assign BUSY      = (state_reg != IDLE);
    assign IDX       = idx_reg;

endmodule

// File: tb/tb_simd_mac_pe.sv
// Three PE instances (AW=32 sat, AW=16 sat, AW=16 wrap) on shared stimulus vs. a transaction-level model.
module tb_simd_mac_pe;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = 3;
    localparam int IW = 2;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    logic [N-1:0][DW-1:0] VEC_IN = '0;
    logic VEC_SEL = 1'b0, VEC_VALID = 1'b0, CMD_VALID = 1'b0;
    logic CMD_SIGNED = 1'b0, CMD_CLR = 1'b0, RES_READY = 1'b0;
    logic [LW-1:0] CMD_LEN = '0;

    logic [31:0] data0;
    logic [15:0] data1, data2;
    logic [2:0]  ovf, valid, vready, cready, busy;
    logic [IW-1:0] idx0, idx1, idx2;

    simd_mac_pe #(.N(N), .DW(DW), .AW(32), .SAT(1)) u0 (
        .CLK(CLK), .RSTN(RSTN), .VEC_IN(VEC_IN), .VEC_SEL(VEC_SEL), .VEC_VALID(VEC_VALID),
        .VEC_READY(vready[0]), .CMD_VALID(CMD_VALID), .CMD_READY(cready[0]), .CMD_LEN(CMD_LEN),
        .CMD_SIGNED(CMD_SIGNED), .CMD_CLR(CMD_CLR), .RES_DATA(data0), .RES_OVF(ovf[0]),
        .RES_VALID(valid[0]), .RES_READY(RES_READY), .IDX(idx0), .BUSY(busy[0]));

    simd_mac_pe #(.N(N), .DW(DW), .AW(16), .SAT(1)) u1 (
        .CLK(CLK), .RSTN(RSTN), .VEC_IN(VEC_IN), .VEC_SEL(VEC_SEL), .VEC_VALID(VEC_VALID),
        .VEC_READY(vready[1]), .CMD_VALID(CMD_VALID), .CMD_READY(cready[1]), .CMD_LEN(CMD_LEN),
        .CMD_SIGNED(CMD_SIGNED), .CMD_CLR(CMD_CLR), .RES_DATA(data1), .RES_OVF(ovf[1]),
        .RES_VALID(valid[1]), .RES_READY(RES_READY), .IDX(idx1), .BUSY(busy[1]));

    simd_mac_pe #(.N(N), .DW(DW), .AW(16), .SAT(0)) u2 (
        .CLK(CLK), .RSTN(RSTN), .VEC_IN(VEC_IN), .VEC_SEL(VEC_SEL), .VEC_VALID(VEC_VALID),
        .VEC_READY(vready[2]), .CMD_VALID(CMD_VALID), .CMD_READY(cready[2]), .CMD_LEN(CMD_LEN),
        .CMD_SIGNED(CMD_SIGNED), .CMD_CLR(CMD_CLR), .RES_DATA(data2), .RES_OVF(ovf[2]),
        .RES_VALID(valid[2]), .RES_READY(RES_READY), .IDX(idx2), .BUSY(busy[2]));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int aw_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit sat_of(input int k);
        return (k != 2);
    endfunction

    function automatic longint data_of(input int k);
        if (k == 0) return longint'(data0);
        if (k == 1) return longint'(data1);
        return longint'(data2);
    endfunction

    // Exact-integer accumulate, then clamp or wrap into AW bits.
    function automatic longint model_add(input longint acc, input longint prod, input int aw,
                                         input bit sat, input bit sgn, output bit ov);
        longint modv, maxv, minv, accv, s;
        modv = longint'(1) << aw;
        if (sgn) begin
            accv = (acc >= modv / 2) ? acc - modv : acc;
            maxv = modv / 2 - 1;
            minv = -(modv / 2);
        end else begin
            accv = acc;
            maxv = modv - 1;
            minv = 0;
        end
        s  = accv + prod;
        ov = (s > maxv) || (s < minv);
        if (ov && sat) s = (s > maxv) ? maxv : minv;
        return s & (modv - 1);
    endfunction

    function automatic longint elem_val(input logic [7:0] v, input bit sgn);
        longint r;
        r = longint'(v);
        if (sgn && v[7]) r = r - 256;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_a [N];
    logic [7:0] m_b [N];
    longint     m_acc [3];
    bit         m_ovf [3];
    bit         m_valid = 0;
    int         m_cnt = 0;
    bit         chk_en = 0;

    always @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0;
                m_ovf[k] = 0;
            end
            m_valid = 0;
            m_cnt   = 0;
            chk_en  = 1;
        end else if (m_valid) begin
            if (RES_READY) m_valid = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end else begin
            if (VEC_VALID) begin
                for (int i = 0; i < N; i++) begin
                    if (VEC_SEL) m_b[i] = VEC_IN[i];
                    else         m_a[i] = VEC_IN[i];
                end
            end
            if (CMD_VALID) begin
                int  len;
                bit  ov;
                len = (int'(CMD_LEN) > N) ? N : int'(CMD_LEN);
                for (int k = 0; k < 3; k++) begin
                    if (CMD_CLR) begin
                        m_acc[k] = 0;
                        m_ovf[k] = 0;
                    end
                    for (int i = 0; i < len; i++) begin
                        m_acc[k] = model_add(m_acc[k],
                                             elem_val(m_a[i], CMD_SIGNED) * elem_val(m_b[i], CMD_SIGNED),
                                             aw_of(k), sat_of(k), CMD_SIGNED, ov);
                        m_ovf[k] = m_ovf[k] | ov;
                    end
                end
                m_cnt = len + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit m_busy;
                m_busy = m_valid || (m_cnt > 0);
                check($sformatf("u%0d.RES_VALID", k), longint'(valid[k]), longint'(m_valid));
                check($sformatf("u%0d.BUSY", k), longint'(busy[k]), longint'(m_busy));
                check($sformatf("u%0d.VEC_READY", k), longint'(vready[k]), longint'(!m_busy));
                check($sformatf("u%0d.CMD_READY", k), longint'(cready[k]), longint'(!m_busy));
                if (m_valid) begin
                    check($sformatf("u%0d.RES_DATA", k), data_of(k), m_acc[k]);
                    check($sformatf("u%0d.RES_OVF", k), longint'(ovf[k]), longint'(m_ovf[k]));
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N-1:0][DW-1:0] mkvec(input int e0, input int e1, input int e2, input int e3);
        logic [N-1:0][DW-1:0] v;
        v[0] = e0[7:0];
        v[1] = e1[7:0];
        v[2] = e2[7:0];
        v[3] = e3[7:0];
        return v;
    endfunction

    task automatic write_vec(input bit sel, input logic [N-1:0][DW-1:0] v);
        VEC_SEL   = sel;
        VEC_IN    = v;
        VEC_VALID = 1'b1;
        step();
        VEC_VALID = 1'b0;
    endtask

    task automatic run_cmd(input int len, input bit sgn, input bit clr, output int lat);
        CMD_LEN    = len[LW-1:0];
        CMD_SIGNED = sgn;
        CMD_CLR    = clr;
        CMD_VALID  = 1'b1;
        step();
        CMD_VALID  = 1'b0;
        VEC_VALID  = 1'b0;
        lat = 0;
        while (valid[0] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (lat >= 40) check("res_valid_timeout", 0, 1);
        $display("cmd len=%0d signed=%0d clr=%0d -> lat=%0d d0=0x%0h d1=0x%0h d2=0x%0h ovf=%b",
                 len, sgn, clr, lat, data0, data1, data2, ovf);
    endtask

    task automatic drain();
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;
    endtask

    // Literal expectation: pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input int k, input longint exp_data, input bit exp_ovf);
        check({name, ".data"}, data_of(k), exp_data);
        check({name, ".ovf"}, longint'(ovf[k]), longint'(exp_ovf));
        check({name, ".model"}, m_acc[k], exp_data);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        longint held;

        RSTN = 1'b0;
        step();
        step();
        RSTN = 1'b1;
        check("reset.RES_DATA0", longint'(data0), 0);
        check("reset.RES_VALID", longint'(valid), 0);
        check("reset.BUSY", longint'(busy), 0);
        check("reset.READY", longint'({vready, cready}), 64'h3f);
        check("reset.IDX", longint'({idx0, idx1, idx2}), 0);

        // unsigned dot product, latency LEN+1
        write_vec(1'b0, mkvec(1, 2, 3, 4));
        write_vec(1'b1, mkvec(5, 6, 7, 8));
        run_cmd(4, 1'b0, 1'b1, lat);
        check("unsigned.latency", lat, 5);
        lit("unsigned", 0, 70, 1'b0);
        drain();

        // chaining with CLR=0
        run_cmd(2, 1'b0, 1'b0, lat);
        lit("chain", 0, 87, 1'b0);
        drain();

        // LEN=0
        run_cmd(0, 1'b0, 1'b1, lat);
        check("len0.latency", lat, 1);
        lit("len0", 0, 0, 1'b0);
        drain();

        // LEN>N clamps
        run_cmd(7, 1'b0, 1'b1, lat);
        check("clamp.latency", lat, 5);
        lit("clamp", 0, 70, 1'b0);
        drain();

        // signed
        write_vec(1'b0, mkvec(-3, 2, 0, 1));
        write_vec(1'b1, mkvec(4, -5, 7, -1));
        run_cmd(4, 1'b1, 1'b1, lat);
        lit("signed.u0", 0, 64'hFFFFFFE9, 1'b0);
        lit("signed.u1", 1, 64'hFFE9, 1'b0);
        drain();

        // unsigned overflow
        write_vec(1'b0, mkvec(255, 255, 255, 255));
        write_vec(1'b1, mkvec(255, 255, 255, 255));
        run_cmd(4, 1'b0, 1'b1, lat);
        lit("usat.u0", 0, 260100, 1'b0);
        lit("usat.u1", 1, 64'hFFFF, 1'b1);
        lit("uwrap.u2", 2, 64'hF804, 1'b1);
        drain();

        // signed overflow
        write_vec(1'b0, mkvec(-128, -128, -128, -128));
        write_vec(1'b1, mkvec(-128, -128, -128, -128));
        run_cmd(4, 1'b1, 1'b1, lat);
        lit("ssat.u0", 0, 65536, 1'b0);
        lit("ssat.u1", 1, 64'h7FFF, 1'b1);
        lit("swrap.u2", 2, 64'h0000, 1'b1);
        drain();

        // vector write and command on the same edge
        write_vec(1'b1, mkvec(1, 2, 3, 4));
        VEC_SEL   = 1'b0;
        VEC_IN    = mkvec(2, 2, 2, 2);
        VEC_VALID = 1'b1;
        run_cmd(4, 1'b0, 1'b1, lat);
        lit("samecycle", 0, 20, 1'b0);

        // backpressure: result held, inputs ignored
        held = longint'(data0);
        for (int c = 0; c < 10; c++) begin
            VEC_SEL   = c[0];
            VEC_IN    = mkvec(9, 9, 9, 9);
            VEC_VALID = 1'b1;
            CMD_VALID = 1'b1;
            step();
            check("hold.RES_VALID", longint'(valid[0]), 1);
            check("hold.RES_DATA", longint'(data0), held);
            check("hold.READY", longint'({vready[0], cready[0]}), 0);
        end
        VEC_VALID = 1'b0;
        CMD_VALID = 1'b0;
        drain();
        run_cmd(4, 1'b0, 1'b1, lat);
        lit("hold.vectors_kept", 0, 20, 1'b0);
        drain();

        // reset in the middle of RUN
        write_vec(1'b0, mkvec(1, 2, 3, 4));
        write_vec(1'b1, mkvec(5, 6, 7, 8));
        CMD_LEN = 3'd4; CMD_SIGNED = 1'b0; CMD_CLR = 1'b1; CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
        lat = 0;
        while (idx0 != 2'd2 && lat < 10) begin
            step();
            lat++;
        end
        if (lat >= 10) check("idx2_timeout", 0, 1);
        RSTN = 1'b0;
        step();
        RSTN = 1'b1;
        check("midreset.BUSY", longint'(busy[0]), 0);
        check("midreset.RES_VALID", longint'(valid[0]), 0);
        check("midreset.RES_DATA", longint'(data0), 0);
        run_cmd(4, 1'b0, 1'b1, lat);
        lit("midreset.vectors_cleared", 0, 0, 1'b0);
        drain();
        write_vec(1'b0, mkvec(1, 2, 3, 4));
        write_vec(1'b1, mkvec(5, 6, 7, 8));
        run_cmd(4, 1'b0, 1'b1, lat);
        lit("midreset.rerun", 0, 70, 1'b0);
        drain();

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 1500; c++) begin
            VEC_VALID  = ($urandom_range(0, 3) == 0);
            VEC_SEL    = $urandom_range(0, 1);
            VEC_IN     = $urandom;
            CMD_VALID  = ($urandom_range(0, 3) == 0);
            CMD_LEN    = LW'($urandom_range(0, 7));
            CMD_SIGNED = $urandom_range(0, 1);
            CMD_CLR    = ($urandom_range(0, 2) != 0);
            RES_READY  = $urandom_range(0, 1);
            RSTN       = ($urandom_range(0, 199) != 0);
            step();
        end
        VEC_VALID = 1'b0;
        CMD_VALID = 1'b0;
        RES_READY = 1'b1;
        RSTN      = 1'b1;
        for (int c = 0; c < 10; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
